// File: rtl/rng_deck_dealer.sv
// Card dealer: a free-running modulo-DECK_SIZE counter picks the starting card and a dealt-card bitmap prevents repeats until reshuffle.
// Optional RNG_DEALER_LFSR_EN: a 16-bit LFSR makes the counter advance 1..4 per clock instead of 1.
module rng_deck_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int CW        = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          ack_i,
    input  logic          shuffle_i,
    output logic [CW-1:0] card_o,
    output logic          valid_o,
    output logic          busy_o,
    output logic          empty_o,
    output logic [CW-1:0] dealt_cnt_o
);

    localparam logic [CW-1:0] LAST = CW'(DECK_SIZE - 1);
    localparam logic [CW-1:0] FULL = CW'(DECK_SIZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_SEARCH  = 2'b01,
        S_PRESENT = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         cand_q, cand_d;
    logic [CW-1:0]         card_q, card_d;
    logic [CW-1:0]         dealt_q, dealt_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  empty_q, empty_d;
    logic [DECK_SIZE-1:0]  bitmap_q, bitmap_d;
    logic [DECK_SIZE-1:0]  cand_sel;
    logic                  cand_taken;

    // One-hot decode of the candidate; avoids indexing the bitmap with a wider index.
    generate
        for (genvar gi = 0; gi < DECK_SIZE; gi++) begin : g_sel
            assign cand_sel[gi] = (cand_q == CW'(gi));
        end
    endgenerate

    assign cand_taken = |(bitmap_q & cand_sel);

`ifdef RNG_DEALER_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [CW:0] step_sum;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1
    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign step_sum = {1'b0, cnt_q} + (CW+1)'(lfsr_q[1:0]) + (CW+1)'(1);

    // Step is at most 4 and DECK_SIZE is at least 4, so one subtraction always lands in range.
    always_comb begin
        cnt_d = step_sum[CW-1:0];
        if (step_sum >= (CW+1)'(DECK_SIZE)) begin
            cnt_d = CW'(step_sum - (CW+1)'(DECK_SIZE));
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
`endif

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        card_d   = card_q;
        dealt_d  = dealt_q;
        valid_d  = valid_q;
        bitmap_d = bitmap_q;
        if (shuffle_i) begin
            bitmap_d = '0;
            dealt_d  = '0;
            valid_d  = 1'b0;
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_i && !empty_q) begin
                        cand_d  = cnt_q;
                        state_d = S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (!cand_taken) begin
                        card_d   = cand_q;
                        bitmap_d = bitmap_q | cand_sel;
                        dealt_d  = dealt_q + 1'b1;
                        valid_d  = 1'b1;
                        state_d  = S_PRESENT;
                    end else begin
                        cand_d = (cand_q == LAST) ? '0 : cand_q + 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (ack_i) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
        empty_d = (dealt_d == FULL);
        busy_d  = (state_d == S_SEARCH) || (state_d == S_PRESENT);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            card_q   <= '0;
            dealt_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            empty_q  <= 1'b0;
            bitmap_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            card_q   <= card_d;
            dealt_q  <= dealt_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            empty_q  <= empty_d;
            bitmap_q <= bitmap_d;
        end
    end

    assign card_o      = card_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;
    assign empty_o     = empty_q;
    assign dealt_cnt_o = dealt_q;

endmodule

// File: tb/tb_rng_deck_dealer.sv
// Bench for rng_deck_dealer: directed scenarios plus randomized deals checked against a deck model.
// Latency is counted in clock edges, the req_i sampling edge being edge 1.
module tb_rng_deck_dealer;

    localparam int N  = 52;
    localparam int N4 = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req, ack, shf;
    logic [7:0] card, dealt;
    logic       valid, busy, empty;
    logic       req4, ack4, shf4;
    logic [7:0] card4, dealt4;
    logic       valid4, busy4, empty4;

    always #5 clk = ~clk;

    rng_deck_dealer #(.DECK_SIZE(N), .CW(8)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .ack_i(ack), .shuffle_i(shf),
        .card_o(card), .valid_o(valid), .busy_o(busy), .empty_o(empty), .dealt_cnt_o(dealt)
    );

    rng_deck_dealer #(.DECK_SIZE(N4), .CW(8)) dut4 (
        .clk_i(clk), .rst_i(rst), .req_i(req4), .ack_i(ack4), .shuffle_i(shf4),
        .card_o(card4), .valid_o(valid4), .busy_o(busy4), .empty_o(empty4), .dealt_cnt_o(dealt4)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;   // edges since reset release; counter value at an edge is cyc mod N
    int ecnt     = 0;
    bit bm[N];
    int m_count  = 0;
    int last_card = 0;
    int last_lat  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ecnt = cyc;
        cyc++;
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) bm[i] = 1'b0;
        m_count = 0;
    endtask

    task automatic wait_cnt(input int t);
        int g;
        g = 0;
        while ((cyc % N) != t && g < 2 * N) begin
            tick();
            g++;
        end
    endtask

    task automatic deal(input bit do_ack, input int ack_delay);
        int start, c, d, lat;
        if (m_count == N) begin
            req = 1'b1;
            repeat (6) begin
                tick();
                check("empty_no_valid", valid, 0);
                check("empty_no_busy", busy, 0);
            end
            req = 1'b0;
            check("empty_flag", empty, 1);
            return;
        end
        req = 1'b1;
        tick();
        req = 1'b0;
        start = ecnt % N;
        check("busy_search", busy, 1);
        c = start;
        d = 0;
        while (bm[c]) begin
            c = (c + 1) % N;
            d++;
        end
        lat = 1;
        while (valid !== 1'b1 && lat < N + 4) begin
            tick();
            lat++;
        end
        check("valid_rise", valid, 1);
`ifdef RNG_DEALER_LFSR_EN
        check("card_range", card < N, 1);
        check("card_unique", (card < N) ? bm[card] : 1'b1, 0);
        check("lat_bound", lat <= N + 1, 1);
        c = (card < N) ? int'(card) : 0;
`else
        check("card", card, c);
        check("latency", lat, 2 + d);
`endif
        bm[c] = 1'b1;
        m_count++;
        last_card = c;
        last_lat  = lat;
        check("dealt_cnt", dealt, m_count);
        check("empty_at_valid", empty, (m_count == N));
        check("busy_present", busy, 1);
        if (do_ack) begin
            repeat (ack_delay) begin
                req = 1'($urandom_range(0, 1));
                tick();
                check("hold_valid", valid, 1);
                check("hold_card", card, c);
            end
            req = 1'b0;
            ack = 1'b1;
            tick();
            ack = 1'b0;
            check("ack_valid", valid, 0);
            check("ack_busy", busy, 0);
        end
        $display("deal: start=%0d card=%0d lat=%0d dealt=%0d", start, card, lat, dealt);
    endtask

    task automatic shuffle(input bit with_ack);
        shf = 1'b1;
        ack = with_ack;
        tick();
        shf = 1'b0;
        ack = 1'b0;
        check("shf_valid", valid, 0);
        check("shf_dealt", dealt, 0);
        check("shf_empty", empty, 0);
        check("shf_busy", busy, 0);
        check("shf_card_kept", card, last_card);
        model_clear();
        $display("shuffle: ack=%0d card_o=%0d", with_ack, card);
    endtask

    initial begin
        int seen4[N4];
        int lat4;
        rst = 1'b0; req = 1'b0; ack = 1'b0; shf = 1'b0;
        req4 = 1'b0; ack4 = 1'b0; shf4 = 1'b0;
        model_clear();
        #12;
        check("rst_card", card, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_empty", empty, 0);
        check("rst_dealt", dealt, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;

        // Scenario 1: request sampled at counter=10
        wait_cnt(10);
        deal(1, 2);
`ifndef RNG_DEALER_LFSR_EN
        check("s1_card", card, 10);
        check("s1_lat", last_lat, 2);
`endif
        // Scenario 2: 10,11,12 taken, request at 10 lands on 13
        wait_cnt(11); deal(1, 0);
        wait_cnt(12); deal(1, 0);
        wait_cnt(10); deal(1, 0);
`ifndef RNG_DEALER_LFSR_EN
        check("s2_card", last_card, 13);
        check("s2_lat", last_lat, 5);
`endif
        // Scenario 4: shuffle (with simultaneous ack) while card 7 is presented
        wait_cnt(7);
        deal(0, 0);
`ifndef RNG_DEALER_LFSR_EN
        check("s4_card", card, 7);
`endif
        shuffle(1'b1);
        wait_cnt(7);
        deal(1, 1);
`ifndef RNG_DEALER_LFSR_EN
        check("s4_again", last_card, 7);
`endif

        // Randomized deals with idle gaps, stray acks and occasional shuffles
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 8)) begin
                ack = 1'($urandom_range(0, 1));
                tick();
            end
            ack = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                deal(0, 0);
                shuffle(1'($urandom_range(0, 1)));
            end else begin
                deal(1, $urandom_range(0, 3));
            end
        end

        // Exhaust the deck, then confirm empty blocks further deals
        while (m_count < N) begin
            repeat ($urandom_range(0, 3)) tick();
            deal(1, 0);
        end
        deal(1, 0);
        shuffle(1'b0);

        // Scenario 5: asynchronous reset while in SEARCH
        wait_cnt(20);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("s5_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("s5_card", card, 0);
        check("s5_valid", valid, 0);
        check("s5_busy0", busy, 0);
        check("s5_empty", empty, 0);
        check("s5_dealt", dealt, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        model_clear();
        last_card = 0;
        wait_cnt(10);
        deal(1, 0);
`ifndef RNG_DEALER_LFSR_EN
        check("s5_card10", last_card, 10);
        check("s5_lat2", last_lat, 2);
`endif

        // Scenario 3: four-card deck
        for (int i = 0; i < N4; i++) seen4[i] = 0;
        for (int k = 0; k < N4; k++) begin
            req4 = 1'b1;
            tick();
            req4 = 1'b0;
            lat4 = 1;
            while (valid4 !== 1'b1 && lat4 < 12) begin
                tick();
                lat4++;
            end
            check("d4_valid", valid4, 1);
            check("d4_range", card4 < N4, 1);
            if (card4 < N4) begin
                check("d4_unique", seen4[card4], 0);
                seen4[card4]++;
            end
            check("d4_lat", lat4 <= N4 + 1, 1);
            check("d4_dealt", dealt4, k + 1);
            check("d4_empty", empty4, (k == N4 - 1));
            $display("deal4: card=%0d lat=%0d dealt=%0d empty=%0d", card4, lat4, dealt4, empty4);
            ack4 = 1'b1;
            tick();
            ack4 = 1'b0;
        end
        req4 = 1'b1;
        repeat (20) begin
            tick();
            check("d4_no_valid", valid4, 0);
            check("d4_no_busy", busy4, 0);
        end
        req4 = 1'b0;
        check("d4_still_empty", empty4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rng_deck_dealer.md
Name: rng_deck_dealer

Overview:
- Parametrised card dealer that replaces the plain wrap-around card counter in the RNG data path.
- A free-running modulo-DECK_SIZE counter is sampled on request. The sampled value is the starting candidate.
- A dealt-card bitmap guarantees that no card repeats until the deck is reshuffled.
- Results are returned over a valid/ack handshake to the RNG control FSM. The block also reports dealt count and deck-empty status.

Parameters:
- DECK_SIZE, 52, number of distinct cards; card values 0..DECK_SIZE-1; legal range 4..255.
- CW, 8, card/count width; must satisfy 2^CW > DECK_SIZE.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req_i  input  1  level request for next card; sampled only in IDLE.
- ack_i  input  1  consumer accepts card_o; meaningful only while valid_o=1.
- shuffle_i  input  1  synchronous reshuffle: clears bitmap and count, aborts any deal.
- card_o  output  CW  dealt card value, stable while valid_o=1.
- valid_o  output  1  card_o holds a new undealt card.
- busy_o  output  1  high in SEARCH and PRESENT.
- empty_o  output  1  all DECK_SIZE cards dealt.
- dealt_cnt_o  output  CW  number of cards dealt since reset/shuffle, 0..DECK_SIZE.

Behaviour:
- Reset (async, rst_i=0): counter=0, bitmap=0, state=IDLE, cand=0, card_o=0, valid_o=0, busy_o=0, empty_o=0, dealt_cnt_o=0.
- Free-running counter:
  - Increments every clock in every state.
  - Wraps DECK_SIZE-1 -> 0. It never reaches DECK_SIZE, so there are no out-of-range cards.
- FSM states: IDLE, SEARCH, PRESENT (2-bit encoding; the unused code returns to IDLE).
- IDLE:
  - If req_i=1 and empty_o=0: cand <= counter, go to SEARCH.
  - If req_i=1 and empty_o=1: stay in IDLE; no deal, no error pulse.
- SEARCH, one bitmap probe per cycle:
  - If bitmap[cand]=0: card_o <= cand, bitmap[cand] <= 1, dealt_cnt_o += 1, valid_o <= 1, go to PRESENT.
  - Else: cand <= (cand==DECK_SIZE-1) ? 0 : cand+1, stay in SEARCH.
- Latency from the req_i sampling edge to valid_o high:
  - Minimum 2 clocks.
  - Maximum DECK_SIZE+1 clocks. This bound holds because SEARCH is only entered with at least one free card.
- PRESENT:
  - valid_o=1; card_o is held.
  - On ack_i=1: valid_o <= 0, go to IDLE.
  - req_i is ignored in PRESENT.
  - A new request is accepted at the earliest one cycle after the ack edge, i.e. back-to-back deals need req_i held.
- empty_o is registered: it is 1 whenever dealt_cnt_o==DECK_SIZE. It is set in the same edge as the final card's valid_o.
- shuffle_i:
  - Highest priority after reset, effective in any state.
  - Next edge: bitmap=0, dealt_cnt_o=0, empty_o=0, valid_o=0, state=IDLE.
  - card_o keeps its last value. The counter is unaffected.
  - A card being presented when shuffle_i hits is discarded and is not counted.
- ack_i outside PRESENT is ignored.
- Simultaneous ack_i and shuffle_i: shuffle wins; the result equals shuffle alone.
- Reset mid-SEARCH or mid-PRESENT: immediate return to reset values; no partial bitmap update survives.
- Arithmetic:
  - All counts and indices are unsigned CW bits.
  - Wrap uses a compare against DECK_SIZE-1, not a power-of-two mask.

Optional Feature:
- Macro: RNG_DEALER_LFSR_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset), advancing every clock.
  - The counter advances by 1+lfsr[1:0] (1..4) per clock modulo DECK_SIZE, using a single conditional subtraction.
  - The starting candidate becomes harder to predict; all other behaviour is identical.
- Undefined:
  - No LFSR logic is present; the counter steps by exactly 1 per clock.

Test Plan:
1. Reset, then req_i=1 at the edge where counter=10 (DECK_SIZE=52, macro off) -> valid_o=1 two clocks later, card_o=10, dealt_cnt_o=1, busy_o=1 until ack_i.
2. Collision: card 10 already dealt, second request sampled at counter=10, cards 11 and 12 also dealt -> three extra SEARCH cycles, card_o=13, latency 5 clocks.
3. DECK_SIZE=4: deal 4 cards with immediate ack -> all values 0..3 seen exactly once; empty_o=1 with the 4th valid_o. A 5th req_i gives no valid_o for 20 cycles and busy_o=0.
4. shuffle_i pulse while valid_o=1 with card_o=7 -> next edge valid_o=0, dealt_cnt_o=0, empty_o=0, state IDLE. The next deal can return 7 again.
5. rst_i driven low asynchronously mid-SEARCH -> all outputs are 0 before the next clock edge. After release, the first deal behaves as in scenario 1.
6. With RNG_DEALER_LFSR_EN defined, 52 deals at random request spacing -> 52 unique values in 0..51, no value ≥52, every latency ≤53 clocks.
